bk_multiword_add_seq: RTL and testbench
=======================================

Name: bk_multiword_add_seq

Overview:
Sequencer that performs wide (W*WORDS-bit) additions on the existing 16-bit Brent-Kung adder by time-multiplexing it one W-bit chunk per cycle. It sits directly around the adder: it drives the adder's a/b/cin inputs and consumes its sum/carry-out. It chains the carry between chunks and assembles the wide result. Operands arrive, and results leave, through valid/ready handshakes.

Parameters:
W, 16, chunk width; must equal the attached adder width.
WORDS, 4, number of chunks per operand (>=2); operand width is W*WORDS.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept operands.
in_a  input  W*WORDS  operand A.
in_b  input  W*WORDS  operand B.
in_cin  input  1  carry-in for the least-significant chunk.
add_a  output  W  to adder operand a.
add_b  output  W  to adder operand b.
add_cin  output  1  to adder carry-in.
add_sum  input  W  from adder sum (combinational).
add_cout  input  1  from adder carry-out (combinational).
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_sum  output  W*WORDS  wide sum.
out_cout  output  1  carry-out of the most-significant chunk.
out_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it takes effect only on a clk rising edge.
- Reset: state=IDLE, chunk index idx=0, carry register=0, operand registers=0, out_sum=0, out_cout=0, out_ovf=0, out_valid=0. in_ready=1 from the first cycle after reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a, in_b; carry<=in_cin; idx<=0; go to RUN.
- RUN:
  - in_ready=0.
  - Combinationally: add_a=A[idx*W +: W], add_b=B[idx*W +: W], add_cin=carry.
  - Each edge: result chunk idx<=add_sum; carry<=add_cout; idx<=idx+1.
  - If idx==WORDS-1: out_cout<=add_cout; out_ovf<=(A_msb==B_msb)&&(add_sum[W-1]!=A_msb); go to DONE.
- DONE:
  - out_valid=1.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
- Adder drive outside RUN: add_a, add_b and add_cin are driven to 0.
- Latency: if operands are accepted at edge T0, out_valid is high in the cycle after edge T0+WORDS. One adder evaluation per cycle.
- Throughput: one operation per WORDS+2 cycles when out_ready is held high.
- Backpressure: while out_valid&&!out_ready, out_sum, out_cout and out_ovf hold stable and in_ready=0.
- Input stability: in_a, in_b and in_cin are sampled only on the accept edge; later changes to them have no effect.
- Carry and wrap: the carry chains chunk to chunk. No carry enters the next operation; each operation starts from its own in_cin.
- Reset mid-operation (RUN or DONE): the operation is discarded and all state returns to its reset values on that edge. No partial result is ever presented.
- Result holding: out_sum, out_cout and out_ovf are updated only at the end of RUN. They keep the last result while in IDLE.
- Simultaneous rst and in_valid: rst wins; no operation is accepted.

Test Plan:
1. Carry across a chunk boundary: a=0x0000_0000_0000_FFFF, b=0x1, cin=0 -> out_sum=0x0000_0000_0001_0000, out_cout=0, out_ovf=0. out_valid rises 4 cycles after the accept edge.
2. Full ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> out_sum=0, out_cout=1, out_ovf=0. add_cin=1 on every RUN cycle.
3. Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> out_sum=0x8000_0000_0000_0000, out_ovf=1, out_cout=0.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid, with a second operand pair already on in_valid -> out_sum is stable and in_ready=0 throughout. The second pair is accepted 1 cycle after the out_ready handshake.
5. Reset mid-RUN: assert rst at idx=2 -> next cycle in_ready=1, out_valid=0, out_sum=0, add_a=0, add_b=0, add_cin=0. A following 0x1+0x1 operation returns 0x2.
6. Random: 64 random pairs with random cin and random out_ready stalls -> every result matches {cout,sum}=a+b+cin, with no lost or duplicated results.

Source files
------------

// File: rtl/bk_multiword_add_seq_if.sv
// rtl/bk_multiword_add_seq_if.sv - operand/result handshakes and adder port bundle for the wide-add sequencer
interface bk_multiword_add_seq_if #(
  parameter int W     = 16,
  parameter int WORDS = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [W*WORDS-1:0]   in_a;
  logic [W*WORDS-1:0]   in_b;
  logic                 in_cin;
  logic [W-1:0]         add_a;
  logic [W-1:0]         add_b;
  logic                 add_cin;
  logic [W-1:0]         add_sum;
  logic                 add_cout;
  logic                 out_valid;
  logic                 out_ready;
  logic [W*WORDS-1:0]   out_sum;
  logic                 out_cout;
  logic                 out_ovf;

  // Sequencer side: takes operands and adder results, drives the adder and the result.
  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
  );

  // Environment side: supplies operands, models the adder, consumes the result.
  modport master (
    output in_valid, in_a, in_b, in_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/bk_multiword_add_seq.sv
// rtl/bk_multiword_add_seq.sv - wide adder built by time-multiplexing one W-bit adder chunk per cycle
module bk_multiword_add_seq #(
  parameter int W     = 16,
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  bk_multiword_add_seq_if.slave   bus
);
  localparam int N     = W * WORDS;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  // Operands shift right one chunk per RUN cycle so the live chunk is always the low W bits.
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  // Operand sign bits kept aside because the shifting registers lose them.
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  // Partial result fills from the top; after WORDS shifts it is the full sum.
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             last_chunk;

  assign last_chunk = (idx_q == IDX_W'(WORDS - 1));

  // Next-state, datapath updates and handshake/adder outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    a_d          = a_q;
    b_d          = b_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    acc_d        = acc_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    ovf_d        = ovf_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    bus.add_cin   = 1'b0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          a_msb_d = bus.in_a[N-1];
          b_msb_d = bus.in_b[N-1];
          carry_d = bus.in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.add_a   = a_q[W-1:0];
        bus.add_b   = b_q[W-1:0];
        bus.add_cin = carry_q;
        a_d         = a_q >> W;
        b_d         = b_q >> W;
        acc_d       = {bus.add_sum, acc_q[N-1:W]};
        carry_d     = bus.add_cout;
        idx_d       = idx_q + 1'b1;
        if (last_chunk) begin
          sum_d   = acc_d;
          cout_d  = bus.add_cout;
          ovf_d   = (a_msb_q == b_msb_q) && (bus.add_sum[W-1] != a_msb_q);
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out_sum  = sum_q;
  assign bus.out_cout = cout_q;
  assign bus.out_ovf  = ovf_q;
endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// tb/tb_bk_multiword_add_seq.sv - directed and random checks of the wide-add sequencer
module tb_bk_multiword_add_seq;
  localparam int W     = 16;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bk_multiword_add_seq_if #(.W(W), .WORDS(WORDS)) bus();
  bk_multiword_add_seq #(.W(W), .WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Stand-in for the attached 16-bit adder.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{W{1'b0}}, bus.add_cin};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair, wait (bounded) for in_ready, take the accept edge, then scramble inputs.
  task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20 && !bus.in_ready; k++) step();
    chk("in_ready_wait", N'(bus.in_ready), N'(1));
    step();
    bus.in_valid = 1'b0;
    bus.in_a     = {$urandom(), $urandom()};
    bus.in_b     = {$urandom(), $urandom()};
    bus.in_cin   = ~cin;
  endtask

  // Walk the WORDS RUN cycles, checking adder drive and the chained carry.
  task automatic run_check(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
    logic          c;
    logic [W-1:0]  ca, cb;
    c = cin;
    for (int i = 0; i < WORDS; i++) begin
      ca = a[i*W +: W];
      cb = b[i*W +: W];
      chk("run_in_ready", N'(bus.in_ready), N'(0));
      chk("run_out_valid", N'(bus.out_valid), N'(0));
      chk("add_a", N'(bus.add_a), N'(ca));
      chk("add_b", N'(bus.add_b), N'(cb));
      chk("add_cin", N'(bus.add_cin), N'(c));
      c = ({1'b0, ca} + {1'b0, cb} + {{W{1'b0}}, c}) >> W;
      step();
    end
  endtask

  task automatic result_check(input logic [N-1:0] s, input logic co, input logic ov);
    chk("out_valid", N'(bus.out_valid), N'(1));
    chk("done_in_ready", N'(bus.in_ready), N'(0));
    chk("out_sum", bus.out_sum, s);
    chk("out_cout", N'(bus.out_cout), N'(co));
    chk("out_ovf", N'(bus.out_ovf), N'(ov));
    chk("idle_add_a", N'(bus.add_a), N'(0));
  endtask

  // Stall for a number of cycles, then hand the result off and confirm it is presented once.
  task automatic drain(input int stall, input logic [N-1:0] s);
    bus.out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      step();
      chk("stall_valid", N'(bus.out_valid), N'(1));
      chk("stall_sum", bus.out_sum, s);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("post_valid", N'(bus.out_valid), N'(0));
    chk("hold_sum", bus.out_sum, s);
  endtask

  task automatic full_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                         input logic [N-1:0] s, input logic co, input logic ov, input int stall);
    accept(a, b, cin);
    run_check(a, b, cin);
    result_check(s, co, ov);
    drain(stall, s);
  endtask

  logic [N-1:0] ra, rb, rs;
  logic         rc, rco, rov;
  logic [N:0]   full;

  initial begin
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", N'(bus.in_ready), N'(1));
    chk("rst_out_valid", N'(bus.out_valid), N'(0));
    chk("rst_out_sum", bus.out_sum, N'(0));
    chk("rst_out_cout", N'(bus.out_cout), N'(0));
    chk("rst_out_ovf", N'(bus.out_ovf), N'(0));

    // Carry across the first chunk boundary; run_check also pins latency at WORDS cycles.
    full_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 0);
    // Full ripple from carry-in.
    full_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 0);
    // Signed overflow.
    full_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1);

    // Backpressure with a second pair already waiting.
    accept(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    run_check(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    result_check(64'h0, 1'b1, 1'b1);
    bus.in_a = 64'h1234_5678_9ABC_DEF0; bus.in_b = 64'h1111_1111_1111_1111; bus.in_cin = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", N'(bus.in_ready), N'(0));
      chk("bp_out_valid", N'(bus.out_valid), N'(1));
      chk("bp_out_sum", bus.out_sum, N'(0));
      chk("bp_out_ovf", N'(bus.out_ovf), N'(1));
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_handoff_ready", N'(bus.in_ready), N'(1));
    chk("bp_handoff_valid", N'(bus.out_valid), N'(0));
    step();
    bus.in_valid = 1'b0;
    chk("bp_second_accepted", N'(bus.in_ready), N'(0));
    run_check(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1);
    result_check(64'h2345_6789_ABCD_F002, 1'b0, 1'b0);
    drain(0, 64'h2345_6789_ABCD_F002);

    // Reset at idx=2 discards the operation.
    accept(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_in_ready", N'(bus.in_ready), N'(1));
    chk("mid_rst_out_valid", N'(bus.out_valid), N'(0));
    chk("mid_rst_out_sum", bus.out_sum, N'(0));
    chk("mid_rst_add_a", N'(bus.add_a), N'(0));
    chk("mid_rst_add_b", N'(bus.add_b), N'(0));
    chk("mid_rst_add_cin", N'(bus.add_cin), N'(0));
    full_op(64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0, 0);

    // Reset beats a simultaneous in_valid.
    bus.in_a = 64'h5; bus.in_b = 64'h6; bus.in_cin = 1'b0;
    rst = 1'b1; bus.in_valid = 1'b1;
    step();
    rst = 1'b0; bus.in_valid = 1'b0;
    chk("rst_vs_valid", N'(bus.in_ready), N'(1));
    chk("rst_vs_valid_sum", bus.out_sum, N'(0));

    // Random pairs with random stalls.
    for (int t = 0; t < 64; t++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) ra[31:0] = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) rb = ~ra;
      rc   = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc};
      rs   = full[N-1:0];
      rco  = full[N];
      rov  = (ra[N-1] == rb[N-1]) && (rs[N-1] != ra[N-1]);
      full_op(ra, rb, rc, rs, rco, rov, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
